// File: rtl/rect_draw.sv
// Rectangle rasteriser: on go, walks a W x H pixel block in raster order from a
// latched top-left corner, emitting one VGA write per cycle, then pulses done.
module rect_draw #(
   parameter int W = 4,
   parameter int H = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic [7:0] x_coords,
   input  logic [6:0] y_coords,
   input  logic [2:0] input_colour,
   input  logic       erase,
   input  logic       outline,
   output logic [7:0] finalX,
   output logic [6:0] finalY,
   output logic [2:0] output_colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam int XW = (W > 1) ? $clog2(W) : 1;
   localparam int YW = (H > 1) ? $clog2(H) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [7:0]      base_x_r;
   logic [6:0]      base_y_r;
   logic [2:0]      colour_r;
   logic            outline_r;
   logic [XW-1:0]   xoff_r;
   logic [YW-1:0]   yoff_r;
   logic            row_end_s;
   logic            last_s;
   logic            border_s;

   // Scan position decode: end of row, last pixel, and border membership.
   always_comb begin
      row_end_s = (xoff_r == X_LAST);
      last_s    = row_end_s && (yoff_r == Y_LAST);
      border_s  = (xoff_r == '0) || row_end_s || (yoff_r == '0) || (yoff_r == Y_LAST);
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (go) state_s = SCAN;
            else    state_s = IDLE;
         end
         SCAN: begin
            if (last_s) state_s = DONE;
            else        state_s = SCAN;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output decode; all outputs depend only on registered state.
   always_comb begin
      finalX        = base_x_r;
      finalY        = base_y_r;
      output_colour = 3'b000;
      plot          = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_r)
         SCAN: begin
            finalX        = base_x_r + 8'(xoff_r);
            finalY        = base_y_r + 7'(yoff_r);
            output_colour = colour_r;
            plot          = outline_r ? border_s : 1'b1;
            busy          = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // State, latched job parameters and offset counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r   <= IDLE;
         base_x_r  <= 8'd0;
         base_y_r  <= 7'd0;
         colour_r  <= 3'b000;
         outline_r <= 1'b0;
         xoff_r    <= '0;
         yoff_r    <= '0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (go) begin
                  base_x_r  <= x_coords;
                  base_y_r  <= y_coords;
                  colour_r  <= erase ? 3'b000 : input_colour;
                  outline_r <= outline;
                  xoff_r    <= '0;
                  yoff_r    <= '0;
               end else begin
                  xoff_r <= xoff_r;
               end
            end
            SCAN: begin
               // Offsets wrap to zero after the last pixel so IDLE starts clean.
               if (row_end_s) begin
                  xoff_r <= '0;
                  if (yoff_r == Y_LAST) yoff_r <= '0;
                  else                  yoff_r <= yoff_r + 1'b1;
               end else begin
                  xoff_r <= xoff_r + 1'b1;
               end
            end
            default: begin
               xoff_r <= '0;
               yoff_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_draw.sv
// Directed bench for rect_draw: a 4x4 instance for the main scenarios and a
// 3x3 instance for the outline-only pattern.
module tb_rect_draw;

   logic       clk = 1'b0;
   logic       resetn;
   logic       go;
   logic       go3;
   logic [7:0] x_coords;
   logic [6:0] y_coords;
   logic [2:0] input_colour;
   logic       erase;
   logic       outline;

   logic [7:0] finalX,  finalX3;
   logic [6:0] finalY,  finalY3;
   logic [2:0] output_colour, output_colour3;
   logic       plot, plot3, busy, busy3, done, done3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rect_draw #(.W(4), .H(4)) dut (
      .clk(clk), .resetn(resetn), .go(go),
      .x_coords(x_coords), .y_coords(y_coords), .input_colour(input_colour),
      .erase(erase), .outline(outline),
      .finalX(finalX), .finalY(finalY), .output_colour(output_colour),
      .plot(plot), .busy(busy), .done(done)
   );

   rect_draw #(.W(3), .H(3)) dut3 (
      .clk(clk), .resetn(resetn), .go(go3),
      .x_coords(x_coords), .y_coords(y_coords), .input_colour(input_colour),
      .erase(erase), .outline(outline),
      .finalX(finalX3), .finalY(finalY3), .output_colour(output_colour3),
      .plot(plot3), .busy(busy3), .done(done3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One SCAN pixel of the 4x4 instance.
   task automatic pix(input int xo, input int yo, input logic [7:0] bx, input logic [6:0] by,
                      input logic [2:0] c, input logic p);
      logic [7:0] ex;
      logic [6:0] ey;
      ex = bx + 8'(xo);
      ey = by + 7'(yo);
      chk("finalX", 32'(finalX), 32'(ex));
      chk("finalY", 32'(finalY), 32'(ey));
      chk("colour", 32'(output_colour), 32'(c));
      chk("plot",   32'(plot), 32'(p));
      chk("busy",   32'(busy), 32'd1);
      chk("done",   32'(done), 32'd0);
   endtask

   task automatic chk_done();
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy",  32'(busy), 32'd1);
      chk("done_plot",  32'(plot), 32'd0);
      chk("done_col",   32'(output_colour), 32'd0);
   endtask

   task automatic chk_idle(input logic [7:0] bx, input logic [6:0] by);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_plot", 32'(plot), 32'd0);
      chk("idle_x",    32'(finalX), 32'(bx));
      chk("idle_y",    32'(finalY), 32'(by));
   endtask

   task automatic start(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c,
                        input logic er, input logic ol);
      x_coords = bx; y_coords = by; input_colour = c; erase = er; outline = ol;
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   // Full 4x4 scan, done pulse, then IDLE holding the base.
   task automatic run4(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c,
                       input logic ol);
      for (int yo = 0; yo < 4; yo++) begin
         for (int xo = 0; xo < 4; xo++) begin
            pix(xo, yo, bx, by, c, ol ? (xo == 0 || xo == 3 || yo == 0 || yo == 3) : 1'b1);
            tick();
         end
      end
      chk_done();
      tick();
      chk_idle(bx, by);
   endtask

   initial begin
      resetn = 1'b0; go = 1'b0; go3 = 1'b0;
      x_coords = 8'd77; y_coords = 7'd33; input_colour = 3'b011; erase = 1'b0; outline = 1'b0;
      tick(); tick();
      chk_idle(8'd0, 7'd0);
      chk("rst_col", 32'(output_colour), 32'd0);
      resetn = 1'b1;
      tick();
      chk_idle(8'd0, 7'd0);

      // Basic fill at (10,20); inputs scrambled after the first pixel must not matter.
      start(8'd10, 7'd20, 3'b101, 1'b0, 1'b0);
      pix(0, 0, 8'd10, 7'd20, 3'b101, 1'b1);
      x_coords = 8'd99; y_coords = 7'd99; input_colour = 3'b010; erase = 1'b1; outline = 1'b1;
      tick();
      for (int i = 1; i < 16; i++) begin
         pix(i % 4, i / 4, 8'd10, 7'd20, 3'b101, 1'b1);
         tick();
      end
      chk_done();
      tick();
      chk_idle(8'd10, 7'd20);

      // Erase forces black.
      start(8'd40, 7'd50, 3'b111, 1'b1, 1'b0);
      run4(8'd40, 7'd50, 3'b000, 1'b0);

      // Coordinate wrap at the screen edge.
      start(8'd254, 7'd126, 3'b011, 1'b0, 1'b0);
      run4(8'd254, 7'd126, 3'b011, 1'b0);

      // Outline on the 4x4 instance: interior 2x2 suppressed.
      start(8'd1, 7'd2, 3'b110, 1'b0, 1'b1);
      run4(8'd1, 7'd2, 3'b110, 1'b1);

      // go held high: back-to-back with a single IDLE cycle between.
      x_coords = 8'd5; y_coords = 7'd6; input_colour = 3'b001; erase = 1'b0; outline = 1'b0;
      go = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         pix(i % 4, i / 4, 8'd5, 7'd6, 3'b001, 1'b1);
         tick();
      end
      chk_done();
      tick();
      chk_idle(8'd5, 7'd6);
      tick();
      go = 1'b0;
      run4(8'd5, 7'd6, 3'b001, 1'b0);

      // Reset at pixel 7 aborts without a done pulse.
      start(8'd30, 7'd40, 3'b110, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         pix(i % 4, i / 4, 8'd30, 7'd40, 3'b110, 1'b1);
         tick();
      end
      pix(3, 1, 8'd30, 7'd40, 3'b110, 1'b1);
      resetn = 1'b0;
      tick();
      chk_idle(8'd0, 7'd0);
      resetn = 1'b1;
      tick();
      chk_idle(8'd0, 7'd0);
      start(8'd30, 7'd40, 3'b110, 1'b0, 1'b0);
      run4(8'd30, 7'd40, 3'b110, 1'b0);

      // 3x3 outline: only the centre pixel is skipped.
      x_coords = 8'd50; y_coords = 7'd60; input_colour = 3'b100; erase = 1'b0; outline = 1'b1;
      go3 = 1'b1;
      tick();
      go3 = 1'b0;
      for (int yo = 0; yo < 3; yo++) begin
         for (int xo = 0; xo < 3; xo++) begin
            chk("o3_x",    32'(finalX3), 32'(50 + xo));
            chk("o3_y",    32'(finalY3), 32'(60 + yo));
            chk("o3_plot", 32'(plot3), (xo == 1 && yo == 1) ? 32'd0 : 32'd1);
            chk("o3_col",  32'(output_colour3), 32'd4);
            chk("o3_busy", 32'(busy3), 32'd1);
            tick();
         end
      end
      chk("o3_done", 32'(done3), 32'd1);
      chk("o3_plotd", 32'(plot3), 32'd0);
      tick();
      chk("o3_idle", 32'(busy3), 32'd0);
      chk("o3_done0", 32'(done3), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
